conv_stream_engine: RTL and testbench

CONV_STREAM_ENGINE -- requirements
Module: conv_stream_engine

---
 rtl/conv_pkg.sv | 16 +
 rtl/conv_line_buffer.sv | 26 ++
 rtl/conv_stream_engine.sv | 199 +++++++++++++++++++
 tb/tb_conv_stream_engine.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared FSM state type and accumulator sizing for the streaming 2-D convolution engine.
// Types and constant functions only; no latency and no backpressure.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } conv_state_e;

    // Signed product width, plus carry growth over all taps, plus one guard bit.
    function automatic int conv_acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps) + 1;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One-row pixel delay line: the old entry is read and the new one written at the same address.
// Read is combinational and write lands on the clock edge; it has no backpressure and writes on every shift.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = 10,
    parameter int WIDTH = 5
) (
    input  logic                                          clk,
    input  logic                                          wr_en,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0]  addr,
    input  logic [WIDTH-1:0]                              wr_data,
    output logic [WIDTH-1:0]                              rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rd_data = mem_q[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming KxK convolution over a raster frame; the result registers 1 cycle after the completing pixel.
// in_ready drops while an unaccepted result is held, so a stalled out_ready stalls the pixel stream.
module conv_stream_engine
    import conv_pkg::*;
#(
    parameter int IMG_W  = 10,
    parameter int IMG_H  = 10,
    parameter int K      = 3,
    parameter int DATA_W = 5,
    parameter int COEF_W = 5,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 0
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    output logic                                       busy,
    output logic                                       frame_done,
    input  logic                                       coef_we,
    input  logic [((K * K > 1) ? $clog2(K * K) : 1)-1:0] coef_addr,
    input  logic [COEF_W-1:0]                          coef_data,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [DATA_W-1:0]                          in_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [OUT_W-1:0]                           out_data
);

    localparam int KK    = K * K;
    localparam int AW    = (KK > 1) ? $clog2(KK) : 1;
    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW    = $clog2(IMG_W * IMG_H + 1);
    localparam int ACC_W = conv_acc_width(DATA_W, COEF_W, KK);
    localparam int NOUT  = (IMG_W - K + 1) * (IMG_H - K + 1);

    localparam logic [AW-1:0]            TAPS     = AW'(KK);
    localparam logic [CW-1:0]            COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0]            KM1_C    = CW'(K - 1);
    localparam logic [RW-1:0]            KM1_R    = RW'(K - 1);
    localparam logic [PW-1:0]            TOTAL    = PW'(IMG_W * IMG_H);
    localparam logic [PW-1:0]            OUT_LAST = PW'(NOUT - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MAX  = ACC_W'((1 << OUT_W) - 1);

    conv_state_e              state_q, state_d;
    logic [CW-1:0]            col_q, col_d;
    logic [RW-1:0]            row_q, row_d;
    logic [PW-1:0]            pix_cnt_q, pix_cnt_d;
    logic [PW-1:0]            out_cnt_q, out_cnt_d;
    logic signed [COEF_W-1:0] coef_q [KK];
    logic signed [COEF_W-1:0] coef_d [KK];
    logic [DATA_W-1:0]        win_q [K][K];
    logic [DATA_W-1:0]        win_d [K][K];
    logic [DATA_W-1:0]        col_px [K];
    logic                     out_valid_q, out_valid_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  shifted;
    logic [OUT_W-1:0]         sat_val;
    logic                     in_fire;
    logic                     out_fire;
    logic                     win_vld;

    assign in_ready   = (state_q == RUN) && (!out_valid_q || out_ready) && (pix_cnt_q < TOTAL);
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid_q && out_ready;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;

    // col_px[K-1] is the incoming pixel; lower indices are the same column from older rows.
    assign col_px[K-1] = in_data;

    for (genvar j = 0; j < K - 1; j++) begin : g_lb
        conv_line_buffer #(
            .DEPTH (IMG_W),
            .WIDTH (DATA_W)
        ) u_lb (
            .clk     (clk),
            .wr_en   (in_fire),
            .addr    (col_q),
            .wr_data (col_px[K-1-j]),
            .rd_data (col_px[K-2-j])
        );
    end

    always_comb begin
        win_d = win_q;
        if (in_fire) begin
            for (int m = 0; m < K; m++) begin
                for (int n = 0; n < K - 1; n++) begin
                    win_d[m][n] = win_q[m][n + 1];
                end
                win_d[m][K - 1] = col_px[m];
            end
        end
    end

    // The MAC sees the post-shift window so the result can load on the accepting edge.
    always_comb begin
        acc = '0;
        for (int m = 0; m < K; m++) begin
            for (int n = 0; n < K; n++) begin
                acc = acc + ACC_W'($signed({1'b0, win_d[m][n]})) * ACC_W'(coef_q[m * K + n]);
            end
        end
        shifted = acc >>> SHIFT;
        if (shifted[ACC_W-1]) begin
            sat_val = '0;
        end else if (shifted > SAT_MAX) begin
            sat_val = '1;
        end else begin
            sat_val = shifted[OUT_W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        pix_cnt_d   = pix_cnt_q;
        out_cnt_d   = out_cnt_q;
        coef_d      = coef_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        win_vld     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    col_d     = '0;
                    row_d     = '0;
                    pix_cnt_d = '0;
                    out_cnt_d = '0;
                end
            end
            RUN: begin
                if (out_fire && (out_cnt_q == OUT_LAST)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if ((state_q == IDLE) && coef_we && (coef_addr < TAPS)) begin
            coef_d[coef_addr] = coef_data;
        end

        if (in_fire) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            // Columns below K-1 would mix the tail of the previous row into the window.
            win_vld = (row_q >= KM1_R) && (col_q >= KM1_C);
        end

        if (out_fire) begin
            out_valid_d = 1'b0;
            out_cnt_d   = out_cnt_q + 1'b1;
        end
        if (win_vld) begin
            out_valid_d = 1'b1;
            out_data_d  = sat_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            pix_cnt_q   <= '0;
            out_cnt_q   <= '0;
            coef_q      <= '{default: '0};
            win_q       <= '{default: '0};
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            pix_cnt_q   <= pix_cnt_d;
            out_cnt_q   <= out_cnt_d;
            coef_q      <= coef_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed bench for conv_stream_engine at default parameters (10x10 frame, 3x3 kernel, SHIFT=0).
`timescale 1ns/1ps
module tb_conv_stream_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       busy;
    logic       frame_done;
    logic       coef_we = 1'b0;
    logic [3:0] coef_addr = '0;
    logic [4:0] coef_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;

    int n_checks = 0;
    int n_errors = 0;
    int img [100];
    int tb_coef [9];
    int got [$];
    int ref_q [$];
    int n_done;

    conv_stream_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // kind 0: ramp (r*10+c)%32, kind 1: flat 31
    task automatic set_img(input int kind);
        for (int i = 0; i < 100; i++) begin
            img[i] = (kind == 0) ? (i % 32) : 31;
        end
    endtask

    task automatic set_kernel(input int c0, input int c1, input int c2, input int c3, input int c4,
                              input int c5, input int c6, input int c7, input int c8);
        tb_coef = '{c0, c1, c2, c3, c4, c5, c6, c7, c8};
    endtask

    task automatic load_coefs();
        for (int i = 0; i < 9; i++) begin
            coef_we   = 1'b1;
            coef_addr = 4'(i);
            coef_data = 5'(tb_coef[i]);
            @(posedge clk);
            #1;
        end
        coef_we = 1'b0;
    endtask

    function automatic int model_out(input int r, input int c);
        int acc;
        acc = 0;
        for (int m = 0; m < 3; m++) begin
            for (int n = 0; n < 3; n++) begin
                acc += img[(r + m) * 10 + (c + n)] * tb_coef[m * 3 + n];
            end
        end
        if (acc < 0) return 0;
        if (acc > 255) return 255;
        return acc;
    endfunction

    task automatic apply_reset(input string tag);
        in_valid  = 1'b0;
        start     = 1'b0;
        coef_we   = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #2;
        check_val({tag, "/in_ready"},   int'(in_ready),   0);
        check_val({tag, "/out_valid"},  int'(out_valid),  0);
        check_val({tag, "/out_data"},   int'(out_data),   0);
        check_val({tag, "/busy"},       int'(busy),       0);
        check_val({tag, "/frame_done"}, int'(frame_done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string tag, input int rdy_pct, input int abort_at, input bit inject);
        int idx;
        int cyc;
        int prev_data;
        bit prev_stall;
        bit seen;
        got.delete();
        n_done     = 0;
        idx        = 0;
        cyc        = 0;
        prev_data  = 0;
        prev_stall = 1'b0;
        seen       = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (!seen && cyc < 3000) begin
            if (abort_at >= 0 && idx >= abort_at) break;
            in_valid  = (idx < 100);
            in_data   = 5'(img[(idx < 100) ? idx : 0]);
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            start     = inject && (cyc == 20);
            coef_we   = inject && (cyc == 20);
            coef_addr = 4'd4;
            coef_data = 5'd7;
            @(negedge clk);
            if (cyc == 10) check_val({tag, "/busy_run"}, int'(busy), 1);
            if (prev_stall) begin
                check_val({tag, "/stall_vld"}, int'(out_valid), 1);
                check_val({tag, "/stall_dat"}, int'(out_data), prev_data);
            end
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) got.push_back(int'(out_data));
            prev_stall = out_valid && !out_ready;
            prev_data  = int'(out_data);
            if (frame_done) begin
                n_done++;
                seen = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        start     = 1'b0;
        coef_we   = 1'b0;
        if (abort_at < 0) begin
            check_val({tag, "/done_seen"}, int'(seen), 1);
            repeat (3) begin
                @(negedge clk);
                if (frame_done) n_done++;
            end
            check_val({tag, "/done_cnt"}, n_done, 1);
            check_val({tag, "/idle_busy"}, int'(busy), 0);
        end
    endtask

    task automatic frame_check(input string tag, input bit use_const, input int cval);
        check_val({tag, "/count"}, got.size(), 64);
        for (int i = 0; i < got.size() && i < 64; i++) begin
            check_val($sformatf("%s/out%0d", tag, i), got[i], use_const ? cval : model_out(i / 8, i % 8));
        end
    endtask

    initial begin
        #3;
        apply_reset("reset");

        // Identity kernel on the ramp: outputs are the centre pixels.
        set_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
        load_coefs();
        set_img(0);
        run_frame("ident", 100, -1, 1'b0);
        frame_check("ident", 1'b0, 0);
        check_val("ident/first", (got.size() > 0) ? got[0] : -1, 11);
        ref_q = got;

        // Same frame with a 30% out_ready duty cycle must give the identical sequence.
        run_frame("rand", 30, -1, 1'b0);
        frame_check("rand", 1'b0, 0);
        for (int i = 0; i < got.size() && i < ref_q.size(); i++) begin
            check_val($sformatf("rand_vs_free/%0d", i), got[i], ref_q[i]);
        end

        // All-ones kernel on flat 31: 9*31 = 279 clamps to 255.
        set_kernel(1, 1, 1, 1, 1, 1, 1, 1, 1);
        load_coefs();
        set_img(1);
        run_frame("sat_hi", 100, -1, 1'b0);
        frame_check("sat_hi", 1'b1, 255);

        // Single negative tap: every result clamps to 0.
        set_kernel(-1, 0, 0, 0, 0, 0, 0, 0, 0);
        load_coefs();
        set_img(0);
        run_frame("sat_lo", 100, -1, 1'b0);
        frame_check("sat_lo", 1'b1, 0);

        // Asymmetric kernel pins down window orientation (oldest pixel at [0][0]).
        set_kernel(1, 2, 0, 0, 0, 0, 0, 0, 3);
        load_coefs();
        run_frame("asym", 100, -1, 1'b0);
        frame_check("asym", 1'b0, 0);
        check_val("asym/first", (got.size() > 0) ? got[0] : -1, 0 + 2 * 1 + 3 * 22);

        // coef_we and start pulsed mid-frame are ignored.
        set_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
        load_coefs();
        run_frame("inject", 100, -1, 1'b1);
        frame_check("inject", 1'b0, 0);

        // Reset after 37 pixels of a flat frame, then a clean ramp frame.
        set_img(1);
        run_frame("partial", 100, 37, 1'b0);
        apply_reset("midreset");
        load_coefs();
        set_img(0);
        run_frame("after_rst", 100, -1, 1'b0);
        frame_check("after_rst", 1'b0, 0);

        // Coefficients clear on reset: an unloaded kernel yields all zeros.
        apply_reset("coefreset");
        run_frame("zero_coef", 100, -1, 1'b0);
        frame_check("zero_coef", 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
